// File: rtl/fab_accum_alu.sv
// fab_accum_alu: registered add/sub/accumulate/load unit with a valid/ready handshake.
//
// One result is produced per accepted transaction (in_valid_i & in_ready_o), one cycle after
// the accept edge. The result is held while the consumer stalls. A running accumulator serves
// ACC/LOAD, and a wrapping counter counts accepted transactions.
//
// Optional feature: define FAB_ACCUM_SAT_EN to make ACC saturate at all-ones and SUB clamp
// at zero. When it is undefined, both wrap modulo their width.
//
// Ports:
//   clk          clock, rising-edge
//   rst_n        asynchronous active-low reset
//   clr_i        synchronous clear of accumulator and transaction counter
//   a_i, b_i     operands (WIDTH bits)
//   mode_i       00 ADD, 01 SUB, 10 ACC, 11 LOAD
//   in_valid_i   operands/mode valid
//   in_ready_o   block can accept this cycle
//   out_valid_o  result valid
//   out_ready_i  consumer takes result
//   result_o     registered result (ACC_WIDTH bits)
//   flag_o       carry (ADD/ACC), borrow (SUB), 0 for LOAD
//   txn_count_o  accepted-transaction count (CNT_WIDTH bits, wraps)
module fab_accum_alu #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 16,  // must be >= WIDTH+1
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [1:0]           mode_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] result_o,
  output logic                 flag_o,
  output logic [CNT_WIDTH-1:0] txn_count_o
);

  typedef enum logic [1:0] {
    ModeAdd  = 2'b00,
    ModeSub  = 2'b01,
    ModeAcc  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 flag_q, flag_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 accept;
  mode_e                mode;
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [ACC_WIDTH:0]   acc_sum;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign mode       = mode_e'(mode_i);
  assign a_ext      = ACC_WIDTH'(a_i);

  // clr takes priority, so an ACC in the same cycle accumulates onto zero.
  assign acc_base = clr_i ? '0 : acc_q;
  assign add_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign sub_diff = {1'b0, a_i} - {1'b0, b_i};  // top bit set means a < b
  assign acc_sum  = {1'b0, acc_base} + {1'b0, a_ext};

  always_comb begin
    result_d    = result_q;
    flag_d      = flag_q;
    acc_d       = acc_base;
    out_valid_d = out_valid_q;

    if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      unique case (mode)
        ModeAdd: begin
          result_d = ACC_WIDTH'(add_sum);
          flag_d   = add_sum[WIDTH];
        end
        ModeSub: begin
          flag_d = sub_diff[WIDTH];
`ifdef FAB_ACCUM_SAT_EN
          result_d = sub_diff[WIDTH] ? '0 : ACC_WIDTH'(sub_diff[WIDTH-1:0]);
`else
          result_d = ACC_WIDTH'(sub_diff[WIDTH-1:0]);
`endif
        end
        ModeAcc: begin
          flag_d = acc_sum[ACC_WIDTH];
`ifdef FAB_ACCUM_SAT_EN
          acc_d = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
          acc_d = acc_sum[ACC_WIDTH-1:0];
`endif
          result_d = acc_d;
        end
        ModeLoad: begin
          acc_d    = a_ext;
          result_d = a_ext;
          flag_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (accept) begin
      cnt_d = cnt_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flag_o      = flag_q;
  assign txn_count_o = cnt_q;

endmodule

// File: tb/tb_fab_accum_alu.sv
// Scoreboard bench for fab_accum_alu: stimulus pushes expected {result, flag, count} entries,
// and a monitor pops and compares one entry per output handshake.
module tb_fab_accum_alu;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 8;

  localparam logic [1:0] MADD  = 2'b00;
  localparam logic [1:0] MSUB  = 2'b01;
  localparam logic [1:0] MACC  = 2'b10;
  localparam logic [1:0] MLOAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] result;
  logic          flag;
  logic [CW-1:0] txn_count;

  fab_accum_alu #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .a_i        (a),
    .b_i        (b),
    .mode_i     (mode),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .flag_o     (flag),
    .txn_count_o(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] r;
    logic          f;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: a result is consumed when out_valid & out_ready at the sampling point.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_output: got result %0h with empty scoreboard", result);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.r));
        check("flag", 32'(flag), 32'(e.f));
        check("txn_count", 32'(txn_count), 32'(e.c));
      end
    end
  end

  // Issue one transaction while the output is free; it is accepted on the next edge.
  task automatic send(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [AW-1:0] r, input logic f);
    exp_t e;
    mode     = m;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    exp_cnt  = clr ? 8'd1 : exp_cnt + 8'd1;
    e.r = r;
    e.f = f;
    e.c = exp_cnt;
    sb.push_back(e);
    #1;
    check("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] held_r;

    // Reset state while asserted.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with carry out.
    send(MADD, 8'hFF, 8'h01, 16'h0100, 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
`ifdef FAB_ACCUM_SAT_EN
    send(MSUB, 8'h05, 8'h07, 16'h0000, 1'b1);
`else
    send(MSUB, 8'h05, 8'h07, 16'h00FE, 1'b1);
`endif
    send(MSUB, 8'h07, 8'h05, 16'h0002, 1'b0);
    send(MADD, 8'h12, 8'h34, 16'h0046, 1'b0);

    // LOAD then back-to-back ACC.
    send(MLOAD, 8'hF0, 8'h00, 16'h00F0, 1'b0);
    send(MACC, 8'h20, 8'hAA, 16'h0110, 1'b0);
    send(MACC, 8'h20, 8'h00, 16'h0130, 1'b0);
    send(MACC, 8'h20, 8'h00, 16'h0150, 1'b0);

    // Run the accumulator up to and past 0xFFFF; counter also wraps along the way.
    send(MLOAD, 8'hFF, 8'h00, 16'h00FF, 1'b0);
    for (int k = 1; k <= 256; k++) begin
      send(MACC, 8'hFF, 8'h00, 16'(255 * (k + 1)), 1'b0);
    end
`ifdef FAB_ACCUM_SAT_EN
    send(MACC, 8'hFF, 8'h00, 16'hFFFF, 1'b1);
    send(MACC, 8'hFF, 8'h00, 16'hFFFF, 1'b1);
`else
    send(MACC, 8'hFF, 8'h00, 16'h00FE, 1'b1);
    send(MACC, 8'hFF, 8'h00, 16'h01FD, 1'b0);
`endif
    @(posedge clk);
    #1;

    // Back-pressure: hold the result for 3 cycles with a pending input.
    out_ready = 1'b0;
    send(MADD, 8'h10, 8'h20, 16'h0030, 1'b0);
    held_r   = 16'h0030;
    mode     = MADD;
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(held_r));
      check("hold_flag", 32'(flag), 32'd0);
      check("hold_txn", 32'(txn_count), 32'(exp_cnt));
      @(posedge clk);
      #1;
    end
    // Release: the pending input is accepted in the same cycle the held result drains.
    begin
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.r = 16'h0002;
      e.f = 1'b0;
      e.c = exp_cnt;
      sb.push_back(e);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // clr with simultaneous ACC after the accumulator reaches 0x0100.
    send(MLOAD, 8'hF0, 8'h00, 16'h00F0, 1'b0);
    send(MACC, 8'h10, 8'h00, 16'h0100, 1'b0);
    clr = 1'b1;
    send(MACC, 8'h03, 8'h00, 16'h0003, 1'b0);
    send(MACC, 8'h01, 8'h00, 16'h0004, 1'b0);
    // clr alone: zeroes accumulator and counter, leaves the result register alone.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_txn", 32'(txn_count), 32'd0);
    check("clr_keeps_result", 32'(result), 32'h0004);
    exp_cnt = '0;
    send(MACC, 8'h05, 8'h00, 16'h0005, 1'b0);
    // clr with simultaneous ADD completes normally, count ends at 1.
    clr = 1'b1;
    send(MADD, 8'h80, 8'h80, 16'h0100, 1'b1);
    send(MACC, 8'h02, 8'h00, 16'h0002, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a hold.
    out_ready = 1'b0;
    mode      = MADD;
    a         = 8'h01;
    b         = 8'h02;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_result", 32'(result), 32'd0);
    check("async_rst_txn", 32'(txn_count), 32'd0);
    #10;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
